// File: rtl/axi_stream_data_check_if.sv
// Receive-side AXI-stream bus of one Aurora lane: tdata/tkeep/tlast/tvalid.
// There is no tready because the lane cannot be back-pressured.
interface axi_stream_data_check_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic                    tvalid;

  modport master (output tdata, tkeep, tlast, tvalid);
  modport slave  (input  tdata, tkeep, tlast, tvalid);
endinterface

// File: rtl/axi_stream_data_check.sv
// Aurora AXI-stream test-pattern checker: framing, tkeep, channel-ID byte and counter sequence.
// Optional first-error capture is enabled by defining AXIS_CHK_FIRST_ERR_EN.
module axi_stream_data_check #(
  parameter int DATA_WIDTH  = 32,
  parameter int CHANNEL_ID  = 0,
  parameter int BURST_LEN   = 8,
  parameter int LOSS_THRESH = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   sys_clk_i,
  input  logic                   rst_n_i,
  input  logic                   check_en_i,
  input  logic                   channel_up,
  input  logic                   clr_i,
  axi_stream_data_check_if.slave m_axi_rx,
  output logic                   lock_o,
  output logic                   err_flag_o,
  output logic [CNT_WIDTH-1:0]   err_cnt_o,
  output logic [CNT_WIDTH-1:0]   frame_cnt_o,
  output logic [DATA_WIDTH-1:0]  first_err_rx_o,
  output logic [DATA_WIDTH-1:0]  first_err_exp_o
);
  localparam int CW       = DATA_WIDTH - 8;
  localparam int IDX_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int CONSEC_W = $clog2(LOSS_THRESH + 1);
  localparam logic [7:0]          ID_BYTE   = 8'(CHANNEL_ID);
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(BURST_LEN - 1);
  localparam logic [CONSEC_W-1:0] LOSS_LAST = CONSEC_W'(LOSS_THRESH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HUNT = 2'd1,
    ST_LOCK = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  lock_q, lock_d;
  logic                  err_flag_q, err_flag_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
  logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;
  logic [CW-1:0]         exp_cnt_q, exp_cnt_d;
  logic [IDX_W-1:0]      beat_idx_q, beat_idx_d;
  logic [CONSEC_W-1:0]   consec_q, consec_d;
  logic                  frame_ok_q, frame_ok_d;

  logic                  run_s;
  logic                  last_idx_s;
  logic                  beat_err_s;
  logic [7:0]            rx_id_s;
  logic [CW-1:0]         rx_cnt_s;

  assign run_s      = channel_up & check_en_i;
  assign rx_id_s    = m_axi_rx.tdata[DATA_WIDTH-1 -: 8];
  assign rx_cnt_s   = m_axi_rx.tdata[CW-1:0];
  assign last_idx_s = (beat_idx_q == LAST_IDX);
  assign beat_err_s = (rx_id_s != ID_BYTE) | (rx_cnt_s != exp_cnt_q) |
                      (~&m_axi_rx.tkeep) | (m_axi_rx.tlast != last_idx_s);

  // Next-state logic: lock tracking, sequence expectation and status counters.
  always_comb begin
    state_d     = state_q;
    lock_d      = lock_q;
    err_flag_d  = err_flag_q;
    err_cnt_d   = err_cnt_q;
    frame_cnt_d = frame_cnt_q;
    exp_cnt_d   = exp_cnt_q;
    beat_idx_d  = beat_idx_q;
    consec_d    = consec_q;
    frame_ok_d  = frame_ok_q;

    if (!run_s) begin
      state_d  = ST_IDLE;
      lock_d   = 1'b0;
      consec_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_HUNT;
        end
        ST_HUNT: begin
          if (m_axi_rx.tvalid && m_axi_rx.tlast) begin
            state_d    = ST_LOCK;
            lock_d     = 1'b1;
            exp_cnt_d  = rx_cnt_s + CW'(1);
            beat_idx_d = '0;
            consec_d   = '0;
            frame_ok_d = 1'b1;
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_LOCK: begin
          if (m_axi_rx.tvalid) begin
            // The expectation free-runs; it is never reseeded from received data.
            exp_cnt_d  = exp_cnt_q + CW'(1);
            beat_idx_d = last_idx_s ? '0 : beat_idx_q + IDX_W'(1);
            frame_ok_d = last_idx_s ? 1'b1 : (frame_ok_q & ~beat_err_s);
            if (beat_err_s) begin
              err_flag_d = 1'b1;
              err_cnt_d  = (&err_cnt_q) ? err_cnt_q : err_cnt_q + CNT_WIDTH'(1);
              if (consec_q == LOSS_LAST) begin
                state_d  = ST_HUNT;
                lock_d   = 1'b0;
                consec_d = '0;
              end else begin
                consec_d = consec_q + CONSEC_W'(1);
              end
            end else begin
              consec_d = '0;
              if (last_idx_s && frame_ok_q) begin
                frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
              end else begin
                frame_cnt_d = frame_cnt_q;
              end
            end
          end else begin
            state_d = ST_LOCK;
          end
        end
        default: begin
          state_d = ST_IDLE;
          lock_d  = 1'b0;
        end
      endcase
    end

    // Clear wins over any increment made by the same beat.
    if (clr_i) begin
      err_flag_d  = 1'b0;
      err_cnt_d   = '0;
      frame_cnt_d = '0;
    end else begin
      err_flag_d  = err_flag_d;
    end
  end

  // State and status registers with synchronous active-low reset.
  always_ff @(posedge sys_clk_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      lock_q      <= 1'b0;
      err_flag_q  <= 1'b0;
      err_cnt_q   <= '0;
      frame_cnt_q <= '0;
      exp_cnt_q   <= '0;
      beat_idx_q  <= '0;
      consec_q    <= '0;
      frame_ok_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      lock_q      <= lock_d;
      err_flag_q  <= err_flag_d;
      err_cnt_q   <= err_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      exp_cnt_q   <= exp_cnt_d;
      beat_idx_q  <= beat_idx_d;
      consec_q    <= consec_d;
      frame_ok_q  <= frame_ok_d;
    end
  end

  assign lock_o      = lock_q;
  assign err_flag_o  = err_flag_q;
  assign err_cnt_o   = err_cnt_q;
  assign frame_cnt_o = frame_cnt_q;

`ifdef AXIS_CHK_FIRST_ERR_EN
  logic                  capture_s;
  logic [DATA_WIDTH-1:0] first_rx_q;
  logic [DATA_WIDTH-1:0] first_exp_q;

  // The sticky flag is still low exactly until the first counted error.
  assign capture_s = run_s & (state_q == ST_LOCK) & m_axi_rx.tvalid &
                     beat_err_s & ~err_flag_q & ~clr_i;

  // First-error snapshot, held until reset or clear.
  always_ff @(posedge sys_clk_i) begin
    if (!rst_n_i || clr_i) begin
      first_rx_q  <= '0;
      first_exp_q <= '0;
    end else if (capture_s) begin
      first_rx_q  <= m_axi_rx.tdata;
      first_exp_q <= {ID_BYTE, exp_cnt_q};
    end else begin
      first_rx_q  <= first_rx_q;
      first_exp_q <= first_exp_q;
    end
  end

  assign first_err_rx_o  = first_rx_q;
  assign first_err_exp_o = first_exp_q;
`else
  assign first_err_rx_o  = '0;
  assign first_err_exp_o = '0;
`endif
endmodule

// File: tb/tb_axi_stream_data_check.sv
// Self-checking bench for axi_stream_data_check: directed scenarios plus a randomized
// stream compared beat by beat against a behavioural model of the checker rules.
module tb_axi_stream_data_check;
  localparam int DW  = 32;
  localparam int BL  = 8;
  localparam int LT  = 4;
  localparam int CNW = 16;
  localparam logic [7:0] CH = 8'h00;

  logic            sys_clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            check_en = 1'b0;
  logic            channel_up = 1'b0;
  logic            clr = 1'b0;
  logic            lock, err_flag;
  logic [CNW-1:0]  err_cnt, frame_cnt;
  logic [DW-1:0]   frx, fexp;

  int n_checks = 0;
  int n_fail   = 0;
  int gap_max  = 0;

  axi_stream_data_check_if #(.DATA_WIDTH(DW)) rx_if ();

  axi_stream_data_check #(
    .DATA_WIDTH(DW), .CHANNEL_ID(0), .BURST_LEN(BL), .LOSS_THRESH(LT), .CNT_WIDTH(CNW)
  ) dut (
    .sys_clk_i(sys_clk), .rst_n_i(rst_n), .check_en_i(check_en), .channel_up(channel_up),
    .clr_i(clr), .m_axi_rx(rx_if), .lock_o(lock), .err_flag_o(err_flag),
    .err_cnt_o(err_cnt), .frame_cnt_o(frame_cnt),
    .first_err_rx_o(frx), .first_err_exp_o(fexp)
  );

  always #5 sys_clk = ~sys_clk;

  // Behavioural model: mode 0 idle, 1 hunting, 2 locked.
  int          m_mode, m_pos, m_consec;
  logic [23:0] m_exp;
  bit          m_fok, m_flag, m_lock;
  int unsigned m_errs, m_frames;
  logic [31:0] m_frx, m_fexp;

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_consec = 0; m_exp = 24'd0; m_fok = 1'b1;
    m_flag = 1'b0; m_lock = 1'b0; m_errs = 0; m_frames = 0; m_frx = 32'd0; m_fexp = 32'd0;
  endtask

  task automatic model_step(bit up, bit en, bit c, bit v, logic [31:0] d, logic [3:0] k, bit l);
    bit err;
    if (!up || !en) begin
      m_mode = 0; m_lock = 1'b0; m_consec = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (v && l) begin
        m_mode = 2; m_lock = 1'b1; m_exp = d[23:0] + 24'd1; m_pos = 0; m_consec = 0; m_fok = 1'b1;
      end
    end else if (v) begin
      err = (d[31:24] != CH) || (d[23:0] != m_exp) || (k != 4'hF) || (l != (m_pos == BL-1));
      if (err) begin
        if (!m_flag && !c) begin m_frx = d; m_fexp = {CH, m_exp}; end
        if (m_errs < 65535) m_errs++;
        m_flag = 1'b1;
        m_consec++;
      end else begin
        m_consec = 0;
        if (m_pos == BL-1 && m_fok) m_frames = (m_frames + 1) % 65536;
      end
      m_fok = (m_pos == BL-1) ? 1'b1 : (m_fok && !err);
      m_exp = m_exp + 24'd1;
      m_pos = (m_pos + 1) % BL;
      if (m_consec == LT) begin m_mode = 1; m_lock = 1'b0; m_consec = 0; end
    end
    if (c) begin m_errs = 0; m_frames = 0; m_flag = 1'b0; m_frx = 32'd0; m_fexp = 32'd0; end
  endtask

  // One clock: present inputs, let the edge take them, then settle outputs.
  task automatic drive(bit v, logic [31:0] d, logic [3:0] k, bit l, bit c);
    rx_if.tvalid = v; rx_if.tdata = d; rx_if.tkeep = k; rx_if.tlast = l; clr = c;
    @(posedge sys_clk);
    if (!rst_n) model_reset();
    else model_step(channel_up, check_en, c, v, d, k, l);
    #1;
  endtask

  task automatic beat(logic [23:0] cnt, logic [7:0] id, bit l, bit c);
    int g;
    g = $urandom_range(0, gap_max);
    for (int i = 0; i < g; i++) drive(1'b0, $urandom, 4'($urandom), 1'($urandom), 1'b0);
    drive(1'b1, {id, cnt}, 4'hF, l, c);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; channel_up = 1'b1; check_en = 1'b1;
    repeat (3) drive(1'b1, $urandom, 4'hF, 1'b1, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; channel_up = 1'b1; check_en = 1'b1;
    repeat (4) drive(1'b1, $urandom, 4'($urandom), 1'b1, 1'($urandom));
    n_checks++; if (lock !== 1'b0) begin n_fail++; $display("FAIL reset_lock: got %0b want 0", lock); end
    n_checks++; if (err_flag !== 1'b0) begin n_fail++; $display("FAIL reset_flag: got %0b want 0", err_flag); end
    n_checks++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_errcnt: got %0d want 0", err_cnt); end
    n_checks++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_framecnt: got %0d want 0", frame_cnt); end
    n_checks++; if (frx !== 32'd0 || fexp !== 32'd0) begin n_fail++; $display("FAIL reset_first: got %h/%h want 0/0", frx, fexp); end
    rst_n = 1'b1;
  endtask

  task automatic test_clean();
    do_reset(); gap_max = 2;
    for (int i = 0; i < 40; i++) begin
      beat(24'(i), CH, (i % 8) == 7, 1'b0);
      if (i == 6) begin
        n_checks++; if (lock !== 1'b0) begin n_fail++; $display("FAIL clean_prelock: got %0b want 0", lock); end
      end
      if (i == 7) begin
        n_checks++; if (lock !== 1'b1) begin n_fail++; $display("FAIL clean_lock: got %0b want 1", lock); end
      end
    end
    n_checks++; if (frame_cnt !== 16'd4) begin n_fail++; $display("FAIL clean_frames: got %0d want 4", frame_cnt); end
    n_checks++; if (err_cnt !== 16'd0 || err_flag !== 1'b0) begin n_fail++; $display("FAIL clean_errs: got %0d/%0b want 0/0", err_cnt, err_flag); end
  endtask

  task automatic test_cnt_corrupt();
    do_reset(); gap_max = 1;
    for (int i = 0; i < 48; i++) begin
      beat((i == 21) ? 24'h0000FF : 24'(i), CH, (i % 8) == 7, 1'b0);
      if (i == 21) begin
        n_checks++; if (err_cnt !== 16'd1 || err_flag !== 1'b1) begin n_fail++; $display("FAIL corrupt_err: got %0d/%0b want 1/1", err_cnt, err_flag); end
      end
    end
    n_checks++; if (lock !== 1'b1) begin n_fail++; $display("FAIL corrupt_lock: got %0b want 1", lock); end
    n_checks++; if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL corrupt_errcnt: got %0d want 1", err_cnt); end
    n_checks++; if (frame_cnt !== 16'd4) begin n_fail++; $display("FAIL corrupt_frames: got %0d want 4", frame_cnt); end
  endtask

  task automatic test_id_loss();
    do_reset(); gap_max = 1;
    for (int i = 0; i < 24; i++) begin
      beat(24'(i), (i >= 8 && i <= 11) ? 8'h01 : CH, (i % 8) == 7, 1'b0);
      if (i >= 8 && i <= 10) begin
        n_checks++; if (lock !== 1'b1) begin n_fail++; $display("FAIL idloss_hold%0d: got %0b want 1", i, lock); end
      end
      if (i == 11) begin
        n_checks++; if (lock !== 1'b0) begin n_fail++; $display("FAIL idloss_drop: got %0b want 0", lock); end
        n_checks++; if (err_cnt !== 16'd4) begin n_fail++; $display("FAIL idloss_errcnt: got %0d want 4", err_cnt); end
      end
      if (i == 14) begin
        n_checks++; if (lock !== 1'b0) begin n_fail++; $display("FAIL idloss_hunt: got %0b want 0", lock); end
      end
      if (i == 15) begin
        n_checks++; if (lock !== 1'b1) begin n_fail++; $display("FAIL idloss_relock: got %0b want 1", lock); end
      end
    end
    n_checks++; if (frame_cnt !== 16'd1 || err_cnt !== 16'd4) begin n_fail++; $display("FAIL idloss_final: got %0d/%0d want 1/4", frame_cnt, err_cnt); end
  endtask

  task automatic test_tlast_missing();
    do_reset(); gap_max = 2;
    for (int i = 0; i < 24; i++) beat(24'(i), CH, (i == 14) || ((i % 8) == 7 && i != 15), 1'b0);
    n_checks++; if (err_cnt !== 16'd2) begin n_fail++; $display("FAIL tlast_errcnt: got %0d want 2", err_cnt); end
    n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL tlast_frames: got %0d want 1", frame_cnt); end
    n_checks++; if (lock !== 1'b1) begin n_fail++; $display("FAIL tlast_lock: got %0b want 1", lock); end
  endtask

  task automatic test_wrap();
    logic [23:0] c;
    do_reset(); gap_max = 1;
    beat(24'hFFFFFB, CH, 1'b1, 1'b0);
    c = 24'hFFFFFC;
    for (int i = 0; i < 16; i++) begin
      beat(c, CH, (i % 8) == 7, 1'b0);
      c = c + 24'd1;
    end
    n_checks++; if (err_cnt !== 16'd0 || err_flag !== 1'b0) begin n_fail++; $display("FAIL wrap_errs: got %0d/%0b want 0/0", err_cnt, err_flag); end
    n_checks++; if (frame_cnt !== 16'd2) begin n_fail++; $display("FAIL wrap_frames: got %0d want 2", frame_cnt); end
  endtask

  task automatic test_clr();
    do_reset(); gap_max = 1;
    for (int i = 0; i < 33; i++) begin
      if (i == 10) beat(24'h0000AA, CH, 1'b0, 1'b0);
      else if (i == 12) beat(24'h0000BB, CH, 1'b0, 1'b1);
      else if (i == 32) drive(1'b1, 32'h00000099, 4'hF, 1'b0, 1'b0);
      else beat(24'(i), CH, (i % 8) == 7, 1'b0);
      if (i == 10) begin
        n_checks++; if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL clr_pre: got %0d want 1", err_cnt); end
      end
      if (i == 12) begin
        n_checks++; if (err_cnt !== 16'd0 || err_flag !== 1'b0) begin n_fail++; $display("FAIL clr_clear: got %0d/%0b want 0/0", err_cnt, err_flag); end
        n_checks++; if (lock !== 1'b1) begin n_fail++; $display("FAIL clr_state: got %0b want 1", lock); end
      end
    end
    n_checks++; if (err_cnt !== 16'd1 || err_flag !== 1'b1) begin n_fail++; $display("FAIL clr_post: got %0d/%0b want 1/1", err_cnt, err_flag); end
    n_checks++; if (frame_cnt !== 16'd2) begin n_fail++; $display("FAIL clr_frames: got %0d want 2", frame_cnt); end
`ifdef AXIS_CHK_FIRST_ERR_EN
    n_checks++; if (frx !== 32'h00000099 || fexp !== 32'h00000020) begin n_fail++; $display("FAIL clr_first: got %h/%h want 00000099/00000020", frx, fexp); end
`else
    n_checks++; if (frx !== 32'd0 || fexp !== 32'd0) begin n_fail++; $display("FAIL clr_first: got %h/%h want 0/0", frx, fexp); end
`endif
  endtask

  task automatic test_disable_and_reset();
    do_reset(); gap_max = 1;
    for (int i = 0; i < 10; i++) beat((i == 9) ? 24'h000077 : 24'(i), CH, (i % 8) == 7, 1'b0);
    channel_up = 1'b0;
    drive(1'b1, {CH, 24'd10}, 4'hF, 1'b0, 1'b0);
    n_checks++; if (lock !== 1'b0) begin n_fail++; $display("FAIL disable_lock: got %0b want 0", lock); end
    n_checks++; if (err_cnt !== 16'd1 || err_flag !== 1'b1) begin n_fail++; $display("FAIL disable_keep: got %0d/%0b want 1/1", err_cnt, err_flag); end
    channel_up = 1'b1;
    for (int i = 11; i < 15; i++) beat(24'(i), CH, 1'b0, 1'b0);
    n_checks++; if (lock !== 1'b0) begin n_fail++; $display("FAIL disable_nolock: got %0b want 0", lock); end
    beat(24'd15, CH, 1'b1, 1'b0);
    n_checks++; if (lock !== 1'b1) begin n_fail++; $display("FAIL disable_relock: got %0b want 1", lock); end
    rst_n = 1'b0;
    drive(1'b1, {CH, 24'd16}, 4'hF, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 17; i < 20; i++) beat(24'(i), CH, 1'b0, 1'b0);
    n_checks++; if (lock !== 1'b0 || err_cnt !== 16'd0) begin n_fail++; $display("FAIL midreset: got %0b/%0d want 0/0", lock, err_cnt); end
    beat(24'd20, CH, 1'b1, 1'b0);
    n_checks++; if (lock !== 1'b1) begin n_fail++; $display("FAIL midreset_relock: got %0b want 1", lock); end
  endtask

  task automatic test_random();
    logic [23:0] sc;
    logic [31:0] d;
    logic [3:0]  k;
    bit          l;
    int          sp, r, g;
    do_reset(); gap_max = 2;
    sc = 24'($urandom); sp = 0;
    for (int n = 0; n < 700; n++) begin
      r = $urandom_range(0, 99);
      if (r == 10) sc = 24'($urandom);
      d = {CH, sc}; k = 4'hF; l = (sp == BL-1);
      if (r < 3) d[31:24] = 8'($urandom_range(1, 255));
      else if (r < 6) d[23:0] = d[23:0] ^ 24'($urandom_range(1, 255));
      else if (r < 8) k = 4'($urandom_range(0, 14));
      else if (r < 10) l = !l;
      if (r == 11) begin channel_up = 1'b0; drive(1'b0, $urandom, 4'hF, 1'b0, 1'b0); channel_up = 1'b1; end
      if (r == 12) begin check_en = 1'b0; drive(1'b1, d, k, l, 1'b0); check_en = 1'b1; end
      g = $urandom_range(0, gap_max);
      for (int i = 0; i < g; i++) drive(1'b0, $urandom, 4'($urandom), 1'($urandom), 1'b0);
      drive(1'b1, d, k, l, (r == 13) || (r == 14 && n > 350));
      sc = sc + 24'd1; sp = (sp + 1) % BL;
      n_checks++; if (lock !== m_lock) begin n_fail++; $display("FAIL rand_lock@%0d: got %0b want %0b", n, lock, m_lock); end
      n_checks++; if (err_flag !== m_flag) begin n_fail++; $display("FAIL rand_flag@%0d: got %0b want %0b", n, err_flag, m_flag); end
      n_checks++; if (err_cnt !== 16'(m_errs)) begin n_fail++; $display("FAIL rand_errcnt@%0d: got %0d want %0d", n, err_cnt, m_errs); end
      n_checks++; if (frame_cnt !== 16'(m_frames)) begin n_fail++; $display("FAIL rand_frames@%0d: got %0d want %0d", n, frame_cnt, m_frames); end
`ifdef AXIS_CHK_FIRST_ERR_EN
      n_checks++; if (frx !== m_frx || fexp !== m_fexp) begin n_fail++; $display("FAIL rand_first@%0d: got %h/%h want %h/%h", n, frx, fexp, m_frx, m_fexp); end
`else
      n_checks++; if (frx !== 32'd0 || fexp !== 32'd0) begin n_fail++; $display("FAIL rand_first@%0d: got %h/%h want 0/0", n, frx, fexp); end
`endif
    end
  endtask

  initial begin
    rx_if.tvalid = 1'b0; rx_if.tdata = '0; rx_if.tkeep = '0; rx_if.tlast = 1'b0;
    model_reset();
    test_reset();
    test_clean();
    test_cnt_corrupt();
    test_id_loss();
    test_tlast_missing();
    test_wrap();
    test_clr();
    test_disable_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
